// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one single-port memory between requesters A and B.
// Define MEM_ARB_TIMEOUT_EN to add a BUSY watchdog that completes stalled transactions and raises err_o.
module mem_rr_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_valid_i,
  input  logic                  a_wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [WIDTH-1:0]      a_wdata_i,
  output logic                  a_ready_o,
  output logic [WIDTH-1:0]      a_rdata_o,
  input  logic                  b_valid_i,
  input  logic                  b_wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [WIDTH-1:0]      b_wdata_i,
  output logic                  b_ready_o,
  output logic [WIDTH-1:0]      b_rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic [1:0]            grant_o
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                  err_o
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic ptr_q, pick_b, timeout, done;
  // ptr_q=1 favours B when both requesters are valid
  assign pick_b = b_valid_i & (~a_valid_i | ptr_q);
  assign done   = mem_ready_i | timeout;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q;
  assign timeout = ~mem_ready_i & (cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= (state_q == BUSY) ? cnt_q + 1'b1 : '0;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (a_valid_i | b_valid_i) ? BUSY : IDLE;
      BUSY:    state_d = done ? RESP : BUSY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RESP) ptr_q <= grant_o[0];
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_valid_o    <= 1'b0;
      mem_wr_rd_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      grant_o        <= 2'b00;
      a_ready_o      <= 1'b0;
      b_ready_o      <= 1'b0;
      a_rdata_o      <= '0;
      b_rdata_o      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_o          <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (a_valid_i | b_valid_i) begin
          mem_valid_o    <= 1'b1;
          mem_wr_rd_en_o <= pick_b ? b_wr_rd_en_i : a_wr_rd_en_i;
          mem_addr_o     <= pick_b ? b_addr_i : a_addr_i;
          mem_wdata_o    <= pick_b ? b_wdata_i : a_wdata_i;
          grant_o        <= {pick_b, ~pick_b};
        end
        BUSY: if (done) begin
          mem_valid_o <= 1'b0;
          a_ready_o   <= grant_o[0];
          b_ready_o   <= grant_o[1];
          // writes keep the old rdata; a timed-out transaction returns zero
          if (grant_o[0] & (timeout | ~mem_wr_rd_en_o)) a_rdata_o <= timeout ? '0 : mem_rdata_i;
          if (grant_o[1] & (timeout | ~mem_wr_rd_en_o)) b_rdata_o <= timeout ? '0 : mem_rdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
          err_o       <= timeout;
`endif
        end
        default: begin
          a_ready_o <= 1'b0;
          b_ready_o <= 1'b0;
          grant_o   <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
          err_o     <= 1'b0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed vector table plus hand-written multi-cycle sequences for mem_rr_arbiter.
module tb_mem_rr_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic a_valid_i = 1'b0, a_wr_rd_en_i = 1'b0, b_valid_i = 1'b0, b_wr_rd_en_i = 1'b0;
  logic [7:0] a_addr_i = '0, a_wdata_i = '0, b_addr_i = '0, b_wdata_i = '0;
  logic a_ready_o, b_ready_o, mem_valid_o, mem_wr_rd_en_o;
  logic [7:0] a_rdata_o, b_rdata_o, mem_addr_o, mem_wdata_o;
  logic mem_ready_i = 1'b0;
  logic [7:0] mem_rdata_i = '0;
  logic [1:0] grant_o;
`ifdef MEM_ARB_TIMEOUT_EN
  logic err_o;
`endif
  logic [37:0] outv;
  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  mem_rr_arbiter #(.WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_wr_rd_en_i(a_wr_rd_en_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_ready_o(a_ready_o), .a_rdata_o(a_rdata_o),
    .b_valid_i(b_valid_i), .b_wr_rd_en_i(b_wr_rd_en_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_ready_o(b_ready_o), .b_rdata_o(b_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_en_o(mem_wr_rd_en_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o)
`ifdef MEM_ARB_TIMEOUT_EN
    , .err_o(err_o)
`endif
  );

  assign outv = {mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o, grant_o,
                 a_ready_o, a_rdata_o, b_ready_o, b_rdata_o};

  typedef struct {
    logic av, aw; logic [7:0] aa, ad;
    logic bv, bw; logic [7:0] ba, bd;
    logic mr; logic [7:0] md;
    logic [37:0] exp;
  } vec_t;
  vec_t vt[16];

  function automatic logic [37:0] e(input logic mv, mw, input logic [7:0] ma, mwd,
                                    input logic [1:0] g, input logic ar, input logic [7:0] ard,
                                    input logic br, input logic [7:0] brd);
    return {mv, mw, ma, mwd, g, ar, ard, br, brd};
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", n, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] gl[6];
    logic [1:0] pg;
    int ng, ar, br, n;
    // rows: inputs applied before an edge, outputs expected just after it
    vt[0]  = '{1'b1,1'b1,8'h03,8'h11, 1'b1,1'b1,8'h07,8'h22, 1'b0,8'h00, e(1'b1,1'b1,8'h03,8'h11,2'b01,1'b0,8'h00,1'b0,8'h00)};
    vt[1]  = '{1'b1,1'b1,8'h03,8'h11, 1'b1,1'b1,8'h07,8'h22, 1'b1,8'h99, e(1'b0,1'b1,8'h03,8'h11,2'b01,1'b1,8'h00,1'b0,8'h00)};
    vt[2]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h07,8'h22, 1'b0,8'h00, e(1'b0,1'b1,8'h03,8'h11,2'b00,1'b0,8'h00,1'b0,8'h00)};
    vt[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h07,8'h22, 1'b0,8'h00, e(1'b1,1'b1,8'h07,8'h22,2'b10,1'b0,8'h00,1'b0,8'h00)};
    vt[4]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h07,8'h22, 1'b1,8'h77, e(1'b0,1'b1,8'h07,8'h22,2'b10,1'b0,8'h00,1'b1,8'h00)};
    vt[5]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, e(1'b0,1'b1,8'h07,8'h22,2'b00,1'b0,8'h00,1'b0,8'h00)};
    vt[6]  = '{1'b1,1'b0,8'h05,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, e(1'b1,1'b0,8'h05,8'h00,2'b01,1'b0,8'h00,1'b0,8'h00)};
    vt[7]  = '{1'b1,1'b0,8'h05,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,8'hA5, e(1'b0,1'b0,8'h05,8'h00,2'b01,1'b1,8'hA5,1'b0,8'h00)};
    vt[8]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, e(1'b0,1'b0,8'h05,8'h00,2'b00,1'b0,8'hA5,1'b0,8'h00)};
    vt[9]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,8'hFF, e(1'b0,1'b0,8'h05,8'h00,2'b00,1'b0,8'hA5,1'b0,8'h00)};
    vt[10] = '{1'b1,1'b0,8'h09,8'h00, 1'b1,1'b0,8'h12,8'h44, 1'b0,8'h00, e(1'b1,1'b0,8'h12,8'h44,2'b10,1'b0,8'hA5,1'b0,8'h00)};
    vt[11] = '{1'b1,1'b0,8'h09,8'h00, 1'b1,1'b0,8'h12,8'h44, 1'b1,8'h3C, e(1'b0,1'b0,8'h12,8'h44,2'b10,1'b0,8'hA5,1'b1,8'h3C)};
    vt[12] = '{1'b1,1'b0,8'h09,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, e(1'b0,1'b0,8'h12,8'h44,2'b00,1'b0,8'hA5,1'b0,8'h3C)};
    vt[13] = '{1'b1,1'b0,8'h09,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, e(1'b1,1'b0,8'h09,8'h00,2'b01,1'b0,8'hA5,1'b0,8'h3C)};
    vt[14] = '{1'b1,1'b0,8'h09,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,8'h5A, e(1'b0,1'b0,8'h09,8'h00,2'b01,1'b1,8'h5A,1'b0,8'h3C)};
    vt[15] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, e(1'b0,1'b0,8'h09,8'h00,2'b00,1'b0,8'h5A,1'b0,8'h3C)};

    #1;
    chk("reset_outputs", 64'(outv), 64'd0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("reset_err", 64'(err_o), 64'd0);
`endif
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;

    for (int i = 0; i < 16; i++) begin
      a_valid_i = vt[i].av; a_wr_rd_en_i = vt[i].aw; a_addr_i = vt[i].aa; a_wdata_i = vt[i].ad;
      b_valid_i = vt[i].bv; b_wr_rd_en_i = vt[i].bw; b_addr_i = vt[i].ba; b_wdata_i = vt[i].bd;
      mem_ready_i = vt[i].mr; mem_rdata_i = vt[i].md;
      tick();
      chk($sformatf("vec%0d", i), 64'(outv), 64'(vt[i].exp));
    end

    // reset clears held rdata and restores the A-first pointer
    rst_i = 1'b0;
    #1;
    chk("reset_again", 64'(outv), 64'd0);
    @(negedge clk_i) rst_i = 1'b1;

    // fairness: both continuously valid, memory answers on the cycle after mem_valid
    a_valid_i = 1'b1; b_valid_i = 1'b1; a_wr_rd_en_i = 1'b0; b_wr_rd_en_i = 1'b0;
    a_addr_i = 8'h01; b_addr_i = 8'h02; mem_ready_i = 1'b0;
    ng = 0; ar = 0; br = 0; pg = 2'b00;
    for (int c = 0; c < 60 && (ar + br) < 6; c++) begin
      tick();
      if (grant_o != 2'b00 && pg == 2'b00 && ng < 6) begin
        gl[ng] = grant_o;
        ng++;
      end
      ar += int'(a_ready_o);
      br += int'(b_ready_o);
      pg = grant_o;
      mem_ready_i = mem_valid_o;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("fair_grant%0d", i), 64'(gl[i]), (i % 2 == 1) ? 64'd2 : 64'd1);
    chk("fair_a_ready_count", 64'(ar), 64'd3);
    chk("fair_b_ready_count", 64'(br), 64'd3);

    // slow memory: B request held in BUSY for 5 extra cycles while b_addr_i moves
    a_valid_i = 1'b0; b_valid_i = 1'b0; mem_ready_i = 1'b0;
    tick();
    b_valid_i = 1'b1; b_wr_rd_en_i = 1'b0; b_addr_i = 8'h20;
    tick();
    chk("slow_grant", 64'({mem_valid_o, mem_addr_o, grant_o}), 64'({1'b1, 8'h20, 2'b10}));
    b_addr_i = 8'h30;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("slow_hold%0d", i),
          64'({mem_valid_o, mem_wr_rd_en_o, mem_addr_o, grant_o, a_ready_o, b_ready_o}),
          64'({1'b1, 1'b0, 8'h20, 2'b10, 1'b0, 1'b0}));
    end
    mem_ready_i = 1'b1; mem_rdata_i = 8'hC3;
    tick();
    chk("slow_resp", 64'({mem_valid_o, a_ready_o, b_ready_o, b_rdata_o}), 64'({1'b0, 1'b0, 1'b1, 8'hC3}));
    b_valid_i = 1'b0; mem_ready_i = 1'b0;
    tick();
    chk("slow_idle", 64'({grant_o, b_ready_o}), 64'd0);

    // an A write moves the pointer to B before the mid-transaction reset
    a_valid_i = 1'b1; a_wr_rd_en_i = 1'b1; a_addr_i = 8'h40; a_wdata_i = 8'h55;
    tick();
    mem_ready_i = 1'b1;
    tick();
    chk("aw_resp", 64'({a_ready_o, grant_o, a_rdata_o}), 64'({1'b1, 2'b01, 8'h00}));
    a_valid_i = 1'b0; mem_ready_i = 1'b0;
    tick();

    b_valid_i = 1'b1; b_wr_rd_en_i = 1'b0; b_addr_i = 8'h60;
    tick();
    chk("rst_pre_busy", 64'({mem_valid_o, grant_o}), 64'({1'b1, 2'b10}));
    #2 rst_i = 1'b0;
    #1;
    chk("rst_async_clear", 64'(outv), 64'd0);
    a_valid_i = 1'b1; a_wr_rd_en_i = 1'b0; a_addr_i = 8'h50;
    @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    tick();
    chk("rst_then_a", 64'({mem_valid_o, mem_addr_o, grant_o}), 64'({1'b1, 8'h50, 2'b01}));
    mem_ready_i = 1'b1; mem_rdata_i = 8'h77;
    tick();
    chk("rst_then_a_resp", 64'({a_ready_o, a_rdata_o, b_ready_o}), 64'({1'b1, 8'h77, 1'b0}));
    a_valid_i = 1'b0; b_valid_i = 1'b0; mem_ready_i = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    a_valid_i = 1'b1; a_wr_rd_en_i = 1'b0; a_addr_i = 8'h66;
    tick();
    n = 0;
    for (int c = 0; c < 40 && !a_ready_o; c++) begin
      tick();
      n++;
    end
    chk("to_cycles", 64'(n), 64'd16);
    chk("to_resp", 64'({a_ready_o, a_rdata_o, err_o, mem_valid_o}), 64'({1'b1, 8'h00, 1'b1, 1'b0}));
    a_valid_i = 1'b0;
    tick();
    chk("to_err_clear", 64'({err_o, grant_o}), 64'd0);
    b_valid_i = 1'b1; b_wr_rd_en_i = 1'b0; b_addr_i = 8'h70;
    tick();
    mem_ready_i = 1'b1; mem_rdata_i = 8'h81;
    tick();
    chk("to_next_ok", 64'({b_ready_o, b_rdata_o, err_o}), 64'({1'b1, 8'h81, 1'b0}));
    b_valid_i = 1'b0; mem_ready_i = 1'b0;
    tick();
`else
    n = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
